// File: rtl/mem_port_arbiter_if.sv
// Core-side request/response ports, RAM-side bus and stall signals of the
// instruction/data RAM port arbiter.
interface mem_port_arbiter_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned AWIDTH = 8
);
    // Fetch (IF) port
    logic              if_req;
    logic [AWIDTH-1:0] if_addr;
    logic              if_gnt;
    logic              if_valid;
    logic [WIDTH-1:0]  if_rdata;
    // Data (MEM) port
    logic              dm_req;
    logic              dm_we;
    logic [AWIDTH-1:0] dm_addr;
    logic [WIDTH-1:0]  dm_wdata;
    logic              dm_gnt;
    logic              dm_valid;
    logic [WIDTH-1:0]  dm_rdata;
    // RAM macro side
    logic              mem_en;
    logic              mem_we;
    logic [AWIDTH-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;
    logic [WIDTH-1:0]  mem_rdata;
    // Hazard unit
    logic              stall_if;
    logic              stall_mem;

    // Arbiter view
    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
    );

    // Core stages plus RAM macro view
    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between the fetch and memory stages. One access in
// flight at a time; MEM has priority, IF wins after STARVE_MAX consecutive MEM
// grants taken while it was waiting. All RAM-side outputs are registered.
module mem_port_arbiter #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned AWIDTH     = 8,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StAccess, StWait} state_e;

    state_e            state_q, state_d;
    logic              win_dm_q, win_dm_d;   // winner is the MEM port
    logic              win_we_q, win_we_d;   // winner access is a write
    logic [1:0]        lat_q, lat_d;
    logic [3:0]        starve_q, starve_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
    logic              if_gnt_q, if_gnt_d;
    logic              dm_gnt_q, dm_gnt_d;
    logic              if_valid_q, if_valid_d;
    logic              dm_valid_q, dm_valid_d;
    logic [WIDTH-1:0]  if_rdata_q, if_rdata_d;
    logic [WIDTH-1:0]  dm_rdata_q, dm_rdata_d;
    logic              pick_if, pick_dm;

    // Arbitration, access sequencing and starvation tracking
    always_comb begin
        state_d     = state_q;
        win_dm_d    = win_dm_q;
        win_we_d    = win_we_q;
        lat_d       = lat_q;
        starve_d    = starve_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_gnt_d    = 1'b0;
        dm_gnt_d    = 1'b0;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;
        pick_if     = 1'b0;
        pick_dm     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.if_req || bus.dm_req) begin
                    pick_if     = bus.if_req &&
                                  (!bus.dm_req || starve_q == 4'(STARVE_MAX));
                    pick_dm     = !pick_if;
                    state_d     = StAccess;
                    win_dm_d    = pick_dm;
                    win_we_d    = pick_dm && bus.dm_we;
                    mem_en_d    = 1'b1;
                    mem_we_d    = pick_dm && bus.dm_we;
                    mem_addr_d  = pick_dm ? bus.dm_addr : bus.if_addr;
                    if (pick_dm && bus.dm_we) begin
                        mem_wdata_d = bus.dm_wdata;
                    end
                    if_gnt_d    = pick_if;
                    dm_gnt_d    = pick_dm;
                end
            end
            StAccess: begin
                if (win_we_q) begin
                    state_d    = StIdle;
                    dm_valid_d = 1'b1;
                end else if (MEM_LAT <= 1) begin
                    // The valid cycle is already spent back in IDLE, so a
                    // held request re-arbitrates at its closing edge.
                    state_d    = StIdle;
                    if_valid_d = !win_dm_q;
                    dm_valid_d = win_dm_q;
                end else begin
                    state_d = StWait;
                    lat_d   = 2'(MEM_LAT - 2);
                end
            end
            StWait: begin
                if (lat_q == 2'd0) begin
                    state_d    = StIdle;
                    if_valid_d = !win_dm_q;
                    dm_valid_d = win_dm_q;
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Only grants taken while IF is actually waiting count towards starvation
        if (!bus.if_req || pick_if) begin
            starve_d = 4'd0;
        end else if (pick_dm && starve_q != 4'(STARVE_MAX)) begin
            starve_d = starve_q + 4'd1;
        end

        // Read data is live from the RAM in the valid cycle and held afterwards
        if_rdata_d = if_valid_q ? bus.mem_rdata : if_rdata_q;
        dm_rdata_d = (dm_valid_q && !win_we_q) ? bus.mem_rdata : dm_rdata_q;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            win_dm_q    <= 1'b0;
            win_we_q    <= 1'b0;
            lat_q       <= 2'd0;
            starve_q    <= 4'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_gnt_q    <= 1'b0;
            dm_gnt_q    <= 1'b0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            win_dm_q    <= win_dm_d;
            win_we_q    <= win_we_d;
            lat_q       <= lat_d;
            starve_q    <= starve_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_gnt_q    <= if_gnt_d;
            dm_gnt_q    <= dm_gnt_d;
            if_valid_q  <= if_valid_d;
            dm_valid_q  <= dm_valid_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_gnt    = if_gnt_q;
    assign bus.dm_gnt    = dm_gnt_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.dm_valid  = dm_valid_q;
    assign bus.if_rdata  = if_rdata_d;
    assign bus.dm_rdata  = dm_rdata_d;
    assign bus.stall_if  = bus.if_req & ~if_valid_q;
    assign bus.stall_mem = bus.dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LAT=1 and one at
// MEM_LAT=3, each with a RAM model. Expected grants and read data are queued
// by the stimulus and consumed by negedge monitors.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst1, rst3;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.WIDTH(16), .AWIDTH(8)) bus1 ();
    mem_port_arbiter_if #(.WIDTH(16), .AWIDTH(8)) bus3 ();

    mem_port_arbiter #(.WIDTH(16), .AWIDTH(8), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (bus1)
    );

    mem_port_arbiter #(.WIDTH(16), .AWIDTH(8), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
        .clk (clk),
        .rst (rst3),
        .bus (bus3)
    );

    // RAM models: default word is {addr, ~addr}; 0xDEAD when not enabled
    logic [15:0] ram1 [256];
    logic [15:0] ram3 [256];
    logic [15:0] r1_p;
    logic [15:0] r3_p [3];

    always @(posedge clk) begin
        if (rst1) begin
            for (int i = 0; i < 256; i++) ram1[i] <= {i[7:0], ~i[7:0]};
            ram1[8'h10] <= 16'h1234;
            ram1[8'h20] <= 16'h5A5A;
        end else if (bus1.mem_en && bus1.mem_we) begin
            ram1[bus1.mem_addr] <= bus1.mem_wdata;
        end
        r1_p <= bus1.mem_en ? ram1[bus1.mem_addr] : 16'hDEAD;
    end

    always @(posedge clk) begin
        if (rst3) begin
            for (int i = 0; i < 256; i++) ram3[i] <= {i[7:0], ~i[7:0]};
            ram3[8'h50] <= 16'hCAFE;
        end else if (bus3.mem_en && bus3.mem_we) begin
            ram3[bus3.mem_addr] <= bus3.mem_wdata;
        end
        r3_p[0] <= bus3.mem_en ? ram3[bus3.mem_addr] : 16'hDEAD;
        r3_p[1] <= r3_p[0];
        r3_p[2] <= r3_p[1];
    end

    assign bus1.mem_rdata = r1_p;
    assign bus3.mem_rdata = r3_p[2];

    // Scoreboards: grant queues hold 1 for MEM, 0 for IF; dm entries are {is_write, data}
    bit          exp_g1 [$];
    bit          exp_g3 [$];
    logic [15:0] exp_if1 [$];
    logic [15:0] exp_if3 [$];
    logic [16:0] exp_dm1 [$];
    logic [16:0] exp_dm3 [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor for the MEM_LAT=1 instance
    always @(negedge clk) begin : mon1
        logic [16:0] e;
        bit          g;
        if (bus1.if_gnt || bus1.dm_gnt) begin
            chk("gnt1_onehot", {31'd0, bus1.if_gnt & bus1.dm_gnt}, 0);
            chk("gnt1_expected", {31'd0, exp_g1.size() > 0}, 1);
            if (exp_g1.size() > 0) begin
                g = exp_g1.pop_front();
                chk("gnt1_winner_is_dm", {31'd0, bus1.dm_gnt}, {31'd0, g});
            end
        end
        if (bus1.if_valid && bus1.dm_valid) chk("valid1_onehot", 1, 0);
        if (bus1.if_valid) begin
            chk("if_valid1_expected", {31'd0, exp_if1.size() > 0}, 1);
            if (exp_if1.size() > 0) begin
                e = {1'b0, exp_if1.pop_front()};
                chk("if_rdata1", {16'd0, bus1.if_rdata}, {15'd0, e});
            end
        end
        if (bus1.dm_valid) begin
            chk("dm_valid1_expected", {31'd0, exp_dm1.size() > 0}, 1);
            if (exp_dm1.size() > 0) begin
                e = exp_dm1.pop_front();
                if (!e[16]) chk("dm_rdata1", {16'd0, bus1.dm_rdata}, {16'd0, e[15:0]});
            end
        end
    end

    // Monitor for the MEM_LAT=3 instance
    always @(negedge clk) begin : mon3
        logic [16:0] e;
        bit          g;
        if (bus3.if_gnt || bus3.dm_gnt) begin
            chk("gnt3_onehot", {31'd0, bus3.if_gnt & bus3.dm_gnt}, 0);
            chk("gnt3_expected", {31'd0, exp_g3.size() > 0}, 1);
            if (exp_g3.size() > 0) begin
                g = exp_g3.pop_front();
                chk("gnt3_winner_is_dm", {31'd0, bus3.dm_gnt}, {31'd0, g});
            end
        end
        if (bus3.if_valid && bus3.dm_valid) chk("valid3_onehot", 1, 0);
        if (bus3.if_valid) begin
            chk("if_valid3_expected", {31'd0, exp_if3.size() > 0}, 1);
            if (exp_if3.size() > 0) begin
                e = {1'b0, exp_if3.pop_front()};
                chk("if_rdata3", {16'd0, bus3.if_rdata}, {15'd0, e});
            end
        end
        if (bus3.dm_valid) begin
            chk("dm_valid3_expected", {31'd0, exp_dm3.size() > 0}, 1);
            if (exp_dm3.size() > 0) begin
                e = exp_dm3.pop_front();
                if (!e[16]) chk("dm_rdata3", {16'd0, bus3.dm_rdata}, {16'd0, e[15:0]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst1 = 1'b1;
        rst3 = 1'b1;
        bus1.if_req = 0; bus1.if_addr = 0; bus1.dm_req = 0; bus1.dm_we = 0;
        bus1.dm_addr = 0; bus1.dm_wdata = 0;
        bus3.if_req = 0; bus3.if_addr = 0; bus3.dm_req = 0; bus3.dm_we = 0;
        bus3.dm_addr = 0; bus3.dm_wdata = 0;
        step(2);
        rst1 = 1'b0;
        rst3 = 1'b0;
        @(negedge clk);
        chk("rst_mem_en", {31'd0, bus1.mem_en}, 0);
        chk("rst_mem_addr", {24'd0, bus1.mem_addr}, 0);
        chk("rst_gnt_valid", {28'd0, bus1.if_gnt, bus1.dm_gnt, bus1.if_valid, bus1.dm_valid}, 0);
        chk("rst3_mem_en", {31'd0, bus3.mem_en}, 0);

        // Single fetch, MEM_LAT=1
        step(); // C0
        bus1.if_req = 1; bus1.if_addr = 8'h10;
        exp_g1.push_back(0); exp_if1.push_back(16'h1234);
        @(negedge clk);
        chk("t1_stall_if_c0", {31'd0, bus1.stall_if}, 1);
        chk("t1_mem_en_c0", {31'd0, bus1.mem_en}, 0);
        step(); // C1
        @(negedge clk);
        chk("t1_mem_en_c1", {31'd0, bus1.mem_en}, 1);
        chk("t1_mem_addr_c1", {24'd0, bus1.mem_addr}, 32'h10);
        chk("t1_if_gnt_c1", {31'd0, bus1.if_gnt}, 1);
        chk("t1_stall_if_c1", {31'd0, bus1.stall_if}, 1);
        step(); // C2
        bus1.if_req = 0;
        @(negedge clk);
        chk("t1_if_valid_c2", {31'd0, bus1.if_valid}, 1);
        step(); // C3
        @(negedge clk);
        chk("t1_if_rdata_hold", {16'd0, bus1.if_rdata}, 32'h1234);
        chk("t1_mem_en_c3", {31'd0, bus1.mem_en}, 0);
        step(2);

        // Simultaneous IF and MEM read: MEM first, IF after dm_valid
        step(); // C0
        bus1.if_req = 1; bus1.if_addr = 8'h30;
        bus1.dm_req = 1; bus1.dm_we = 0; bus1.dm_addr = 8'h20;
        exp_g1.push_back(1); exp_g1.push_back(0);
        exp_dm1.push_back({1'b0, 16'h5A5A}); exp_if1.push_back(16'h30CF);
        step(); // C1
        @(negedge clk);
        chk("t2_dm_gnt_c1", {31'd0, bus1.dm_gnt}, 1);
        chk("t2_stall_mem_c1", {31'd0, bus1.stall_mem}, 1);
        step(); // C2
        bus1.dm_req = 0;
        @(negedge clk);
        chk("t2_dm_valid_c2", {31'd0, bus1.dm_valid}, 1);
        chk("t2_if_gnt_c2", {31'd0, bus1.if_gnt}, 0);
        step(); // C3
        @(negedge clk);
        chk("t2_if_gnt_c3", {31'd0, bus1.if_gnt}, 1);
        chk("t2_mem_addr_c3", {24'd0, bus1.mem_addr}, 32'h30);
        step(); // C4
        bus1.if_req = 0;
        step(3);

        // Starvation guard: both held for ten grants
        step(); // C0
        bus1.dm_req = 1; bus1.dm_we = 0; bus1.dm_addr = 8'h40;
        bus1.if_req = 1; bus1.if_addr = 8'h41;
        for (int k = 0; k < 10; k++) begin
            exp_g1.push_back(k != 4 && k != 9);
            if (k != 4 && k != 9) exp_dm1.push_back({1'b0, 16'h40BF});
            else exp_if1.push_back(16'h41BE);
        end
        step(20); // C20: valid of tenth access
        bus1.dm_req = 0; bus1.if_req = 0;
        step(3);

        // Write then read back
        step(); // C0
        bus1.dm_req = 1; bus1.dm_we = 1; bus1.dm_addr = 8'h20; bus1.dm_wdata = 16'hBEEF;
        exp_g1.push_back(1); exp_dm1.push_back({1'b1, 16'h0000});
        step(); // C1
        @(negedge clk);
        chk("t4_mem_en_c1", {31'd0, bus1.mem_en}, 1);
        chk("t4_mem_we_c1", {31'd0, bus1.mem_we}, 1);
        chk("t4_mem_addr_c1", {24'd0, bus1.mem_addr}, 32'h20);
        chk("t4_mem_wdata_c1", {16'd0, bus1.mem_wdata}, 32'hBEEF);
        step(); // C2
        bus1.dm_req = 0; bus1.dm_we = 0;
        @(negedge clk);
        chk("t4_dm_valid_c2", {31'd0, bus1.dm_valid}, 1);
        chk("t4_mem_we_c2", {31'd0, bus1.mem_we}, 0);
        step(); // C3
        bus1.dm_req = 1; bus1.dm_addr = 8'h20;
        exp_g1.push_back(1); exp_dm1.push_back({1'b0, 16'hBEEF});
        step(2); // read valid
        bus1.dm_req = 0;
        step(3);

        // MEM_LAT=3 read with a queued fetch
        step(); // C0
        bus3.dm_req = 1; bus3.dm_we = 0; bus3.dm_addr = 8'h50;
        exp_g3.push_back(1); exp_g3.push_back(0);
        exp_dm3.push_back({1'b0, 16'hCAFE}); exp_if3.push_back(16'h51AE);
        step(); // C1
        bus3.if_req = 1; bus3.if_addr = 8'h51;
        @(negedge clk);
        chk("t5_mem_en_c1", {31'd0, bus3.mem_en}, 1);
        step(); // C2
        @(negedge clk);
        chk("t5_mem_en_c2", {31'd0, bus3.mem_en}, 0);
        chk("t5_dm_valid_c2", {31'd0, bus3.dm_valid}, 0);
        chk("t5_stall_mem_c2", {31'd0, bus3.stall_mem}, 1);
        step(); // C3
        @(negedge clk);
        chk("t5_dm_valid_c3", {31'd0, bus3.dm_valid}, 0);
        step(); // C4
        bus3.dm_req = 0;
        @(negedge clk);
        chk("t5_dm_valid_c4", {31'd0, bus3.dm_valid}, 1);
        step(); // C5
        @(negedge clk);
        chk("t5_if_gnt_c5", {31'd0, bus3.if_gnt}, 1);
        chk("t5_mem_addr_c5", {24'd0, bus3.mem_addr}, 32'h51);
        step(3); // C8: fetch valid
        bus3.if_req = 0;
        step(3);

        // Reset in the middle of a MEM_LAT=3 read
        step(); // C0
        bus3.dm_req = 1; bus3.dm_we = 0; bus3.dm_addr = 8'h50;
        exp_g3.push_back(1);
        step(); // C1
        step(); // C2
        rst3 = 1'b1;
        step(); // C3
        rst3 = 1'b0;
        exp_g3.push_back(1); exp_dm3.push_back({1'b0, 16'hCAFE});
        @(negedge clk);
        chk("t6_mem_en_c3", {31'd0, bus3.mem_en}, 0);
        chk("t6_mem_we_c3", {31'd0, bus3.mem_we}, 0);
        chk("t6_mem_addr_c3", {24'd0, bus3.mem_addr}, 0);
        chk("t6_mem_wdata_c3", {16'd0, bus3.mem_wdata}, 0);
        chk("t6_gnt_valid_c3", {28'd0, bus3.if_gnt, bus3.dm_gnt, bus3.if_valid, bus3.dm_valid}, 0);
        step(); // C4
        @(negedge clk);
        chk("t6_dm_gnt_c4", {31'd0, bus3.dm_gnt}, 1);
        chk("t6_dm_valid_c4", {31'd0, bus3.dm_valid}, 0);
        step(3); // C7
        bus3.dm_req = 0;
        @(negedge clk);
        chk("t6_dm_valid_c7", {31'd0, bus3.dm_valid}, 1);
        step(4);

        chk("end_exp_g1_empty", exp_g1.size(), 0);
        chk("end_exp_g3_empty", exp_g3.size(), 0);
        chk("end_exp_if1_empty", exp_if1.size(), 0);
        chk("end_exp_if3_empty", exp_if3.size(), 0);
        chk("end_exp_dm1_empty", exp_dm1.size(), 0);
        chk("end_exp_dm3_empty", exp_dm3.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port instruction/data RAM between the pipelined RISC-V core's fetch (IF) stage and memory (MEM) stage. Exactly one transaction is outstanding at a time. Fixed priority goes to MEM, since it holds the older instruction, with a starvation guard for IF. Stall outputs go to the pipeline hazard logic. Sits between the core stages and the memory macro inside the WIDTH=16 CPU.

Parameters:
WIDTH, 16, data word width
AWIDTH, 8, word address width
MEM_LAT, 1, RAM read latency in cycles (legal 1..3)
STARVE_MAX, 4, consecutive MEM grants allowed while IF waits (legal 1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
if_req  in  1  fetch request
if_addr  in  AWIDTH  fetch address
if_gnt  out  1  one-cycle pulse: fetch issued to RAM
if_valid  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  WIDTH  fetched instruction
dm_req  in  1  data request
dm_we  in  1  1=write, 0=read
dm_addr  in  AWIDTH  data address
dm_wdata  in  WIDTH  write data
dm_gnt  out  1  one-cycle pulse: data access issued
dm_valid  out  1  one-cycle pulse: read data valid or write done
dm_rdata  out  WIDTH  read data
mem_en  out  1  RAM access strobe
mem_we  out  1  RAM write enable
mem_addr  out  AWIDTH  RAM address
mem_wdata  out  WIDTH  RAM write data
mem_rdata  in  WIDTH  RAM read data, valid MEM_LAT cycles after mem_en
stall_if  out  1  if_req & ~if_valid (combinational)
stall_mem  out  1  dm_req & ~dm_valid (combinational)

Behaviour:
- Reset: rst=1 at an edge forces IDLE. Clears the starvation counter and latency counter. All registered outputs go to 0: mem_en, mem_we, mem_addr, mem_wdata, *_gnt, *_valid.
- Reset mid-transaction: the in-flight access is dropped and no valid pulse is issued. Late mem_rdata is ignored. Requests still high after rst falls are re-arbitrated from IDLE.
- FSM states: IDLE, ACCESS, WAIT.
- IDLE: requests are sampled at each edge. If any request is present, a winner is latched and the FSM enters ACCESS.
- ACCESS (cycle C1): exactly one cycle.
  - mem_en=1; mem_addr/mem_we/mem_wdata come from the winner's registered copy. The winner's gnt=1.
  - Write: next state IDLE. dm_valid=1 in C1+1.
  - Read: next state WAIT, latency counter loaded.
- WAIT: mem_en=0. In cycle C1+MEM_LAT the winner's valid=1 and its rdata is driven from mem_rdata. The FSM returns to IDLE in that same cycle. For MEM_LAT=1 there are no WAIT cycles before the valid cycle.
- Throughput: back-to-back reads issue one access per MEM_LAT+1 cycles; writes issue one per 2 cycles.
- Requester rules:
  - Hold req, addr, we and wdata stable from assertion until valid.
  - A req still high at the edge ending the valid cycle is treated as a new request.
  - Input changes while not in IDLE are ignored (values were latched at arbitration).
- Arbitration (IDLE, both requesting): MEM wins unless starve_cnt==STARVE_MAX, in which case IF wins.
  - starve_cnt increments on each MEM grant while if_req=1, saturating at STARVE_MAX.
  - starve_cnt clears on any IF grant or any cycle with if_req=0.
- Idle outputs: *_rdata hold their last value when not valid. Only one of if_valid/dm_valid is ever high in a cycle, and only one gnt.
- No combinational path from req to mem_* outputs.

Test Plan:
1. MEM_LAT=1, RAM[0x10]=0x1234, if_req=1, if_addr=0x10 at C0 -> C1: mem_en=1, mem_addr=0x10, if_gnt=1; C2: if_valid=1, if_rdata=0x1234; stall_if=1 in C0..C1.
2. if_req and dm_req (read 0x20) rise together -> dm_gnt first, dm_valid 2 cycles later; if_gnt on the next cycle after dm_valid, never overlapping.
3. STARVE_MAX=4, dm_req and if_req held high continuously -> grant order D,D,D,D,I,D,D,D,D,I.
4. dm_we=1, dm_addr=0x20, dm_wdata=0xBEEF -> mem_we=1 with those values in C1, dm_valid in C2; a following read of 0x20 returns 0xBEEF.
5. MEM_LAT=3 read -> mem_en only in C1, dm_valid in C4; a queued if_req gets if_gnt in C5.
6. rst pulsed in C2 of a MEM_LAT=3 read -> no dm_valid; all outputs 0 at C3; with dm_req still high, re-grant occurs in the first cycle after rst falls plus one.
